// File: rtl/cache_store_buffer.sv
// Store buffer between the CPU datapath and the cache write-merge stage.
// Oldest-first drain, youngest-entry coalescing and per-byte store-to-load forwarding.
module cache_store_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [15:0]              st_addr,
    input  logic [15:0]              st_wdata,
    input  logic [1:0]               st_wmask,
    output logic                     drain_valid,
    input  logic                     drain_ready,
    output logic [15:0]              drain_addr,
    output logic [3:0]               drain_offset,
    output logic [1:0]               drain_wmask,
    output logic [7:0]               drain_lsb,
    output logic [7:0]               drain_msb,
    input  logic [15:0]              ld_addr,
    output logic [1:0]               fwd_mask,
    output logic [15:0]              fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    yng_ptr;
    logic [CW-1:0]    count_q;
    logic [DEPTH-1:0] entry_valid;
    logic [14:0]      entry_addr  [DEPTH];
    logic [15:0]      entry_data  [DEPTH];
    logic [1:0]       entry_wmask [DEPTH];

    logic empty;
    logic pop;
    logic merge_hit;
    logic accept;
    logic do_write;
    logic push;
    logic [PW-1:0] fwd_idx;

    // Byte address bit 0 is meaningless for word-granular entries.
    logic unused_bits;
    assign unused_bits = st_addr[0] ^ ld_addr[0];

    assign empty   = (count_q == '0);
    assign yng_ptr = wr_ptr - PW'(1);
    assign pop     = !empty && drain_ready;

    // A single entry that is being popped cannot absorb a merge; the store becomes a new entry.
    assign merge_hit = !empty
                    && (st_addr[15:1] == entry_addr[yng_ptr])
                    && !((yng_ptr == rd_ptr) && pop);

    assign st_ready = (count_q < CW'(DEPTH)) || merge_hit;
    assign accept   = st_valid && st_ready;
    assign do_write = accept && (st_wmask != 2'b00);
    assign push     = do_write && !merge_hit;
    assign count    = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            entry_valid <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (pop) begin
                rd_ptr              <= rd_ptr + PW'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr              <= wr_ptr + PW'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: payload storage has no reset; it is only observed through valid/count-qualified paths.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[wr_ptr]  <= st_addr[15:1];
            entry_data[wr_ptr]  <= st_wdata;
            entry_wmask[wr_ptr] <= st_wmask;
        end else if (do_write) begin
            entry_wmask[yng_ptr] <= entry_wmask[yng_ptr] | st_wmask;
            if (st_wmask[0]) entry_data[yng_ptr][7:0]  <= st_wdata[7:0];
            if (st_wmask[1]) entry_data[yng_ptr][15:8] <= st_wdata[15:8];
        end
    end

    assign drain_valid  = !empty;
    assign drain_offset = drain_addr[3:0];

    always_comb begin
        // NOTE: defaults first so no path through the block leaves an output unassigned (no latches).
        drain_addr  = '0;
        drain_wmask = '0;
        drain_lsb   = '0;
        drain_msb   = '0;
        if (!empty) begin
            drain_addr  = {entry_addr[rd_ptr], 1'b0};
            drain_wmask = entry_wmask[rd_ptr];
            drain_lsb   = entry_data[rd_ptr][7:0];
            drain_msb   = entry_data[rd_ptr][15:8];
        end
    end

    // Scan oldest to youngest so younger matches override older ones byte by byte.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        fwd_idx  = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (entry_valid[fwd_idx] && (entry_addr[fwd_idx] == ld_addr[15:1])) begin
                if (entry_wmask[fwd_idx][0]) begin
                    fwd_mask[0]   = 1'b1;
                    fwd_data[7:0] = entry_data[fwd_idx][7:0];
                end
                if (entry_wmask[fwd_idx][1]) begin
                    fwd_mask[1]    = 1'b1;
                    fwd_data[15:8] = entry_data[fwd_idx][15:8];
                end
            end
        end
    end

endmodule
